// File: rtl/frame_buf_pkg.sv
// Shared constants and FSM state type for the ping-pong frame buffer.
package frame_buf_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_COL_W   = 7;
  localparam int DEF_ROW_W   = 7;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fbState_t;

endpackage

// File: rtl/frame_ram_bank.sv
// One simple dual-port RAM bank: synchronous write, registered read.
module frame_ram_bank
  import frame_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_COL_W + DEF_ROW_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData_p1
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  // Read register clears on reset so the top-level read port starts at zero.
  always_ff @(posedge clock) begin
    if (reset)     rdData_p1 <= '0;
    else if (rdEn) rdData_p1 <= mem[rdAddr];
  end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store with swap handshake, frame counter and read-valid.
// Optional clear-on-swap sweep enabled by defining FRAME_BUF_CLEAR_EN.
module pingpong_frame_buffer
  import frame_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COL_W  = DEF_COL_W,
  parameter int ROW_W  = DEF_ROW_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iWren,
  input  logic [COL_W-1:0]       iWrcol,
  input  logic [ROW_W-1:0]       iWrrow,
  input  logic [DATA_W-1:0]      iWrdata,
  input  logic                   iRden,
  input  logic [COL_W-1:0]       iRdcol,
  input  logic [ROW_W-1:0]       iRdrow,
  output logic [DATA_W-1:0]      oRddata,
  output logic                   oRdvalid,
  input  logic                   iSwap,
  output logic                   oSwapDone,
  output logic                   oWrbank,
  output logic [FRAME_CNT_W-1:0] oFrameCount,
  output logic                   oBusy
);

  localparam int ADDR_W = COL_W + ROW_W;
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE = FRAME_CNT_W'(1);

  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] bankWrAddr;
  logic [DATA_W-1:0] bankWrData;
  logic              bankWrEn;
  logic [DATA_W-1:0] rdData0_p1;
  logic [DATA_W-1:0] rdData1_p1;
  logic              rdSel_p1;
  logic              swapNow;
  logic              pending;
  fbState_t          state;

  assign wrAddr  = {iWrrow, iWrcol};
  assign rdAddr  = {iRdrow, iRdcol};
  assign swapNow = (state == IDLE) && (iSwap || pending);

`ifdef FRAME_BUF_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] clrAddr;
  logic              clrReq;

  assign oBusy      = (state == CLEAR);
  assign bankWrEn   = oBusy || iWren;
  assign bankWrAddr = oBusy ? clrAddr : wrAddr;
  assign bankWrData = oBusy ? '0 : iWrdata;

  // clrReq forces a sweep of bank 0 after reset without counting as a swap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      clrReq  <= 1'b1;
      clrAddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (swapNow || clrReq) begin
            state   <= CLEAR;
            clrReq  <= 1'b0;
            clrAddr <= '0;
          end
        end
        CLEAR: begin
          if (iSwap) pending <= 1'b1;
          clrAddr <= clrAddr + ADDR_ONE;
          if (clrAddr == LAST_ADDR) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign oBusy      = 1'b0;
  assign bankWrEn   = iWren;
  assign bankWrAddr = wrAddr;
  assign bankWrData = iWrdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else if (swapNow) begin
      pending <= 1'b0;
    end
  end
`endif

  // Role registers: writer bank, frame count, swap pulse, read-valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      oWrbank     <= 1'b0;
      oFrameCount <= '0;
      oSwapDone   <= 1'b0;
      oRdvalid    <= 1'b0;
      rdSel_p1    <= 1'b0;
    end else begin
      oSwapDone <= swapNow;
      oRdvalid  <= iRden;
      if (iRden) rdSel_p1 <= ~oWrbank;
      if (swapNow) begin
        oWrbank     <= ~oWrbank;
        oFrameCount <= oFrameCount + CNT_ONE;
      end
    end
  end

  frame_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bank0 (
    .clock     (clock),
    .reset     (reset),
    .wrEn      (bankWrEn && !oWrbank),
    .wrAddr    (bankWrAddr),
    .wrData    (bankWrData),
    .rdEn      (iRden && oWrbank),
    .rdAddr    (rdAddr),
    .rdData_p1 (rdData0_p1)
  );

  frame_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bank1 (
    .clock     (clock),
    .reset     (reset),
    .wrEn      (bankWrEn && oWrbank),
    .wrAddr    (bankWrAddr),
    .wrData    (bankWrData),
    .rdEn      (iRden && !oWrbank),
    .rdAddr    (rdAddr),
    .rdData_p1 (rdData1_p1)
  );

  assign oRddata = rdSel_p1 ? rdData1_p1 : rdData0_p1;

endmodule
